// File: rtl/msc16_mem_arb.sv
// rtl/msc16_mem_arb.sv - two-requester arbiter sharing the single-ported msc16 memory
module msc16_mem_arb #(
  parameter int MEM_LAT    = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_out,
  input  logic [15:0] mem_in,
  output logic        grant_id
);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t     state;
  logic [1:0] wait_cnt;
  logic       last_grant;
  logic       lock_hold;
  logic       cur_we;
  logic       any_req;
  logic       decide;
  logic       win;

  assign any_req = m0_req | m1_req;
  // Decisions happen when idle, or on the last WAIT cycle so back-to-back issues lose no cycle.
  assign decide  = any_req && ((state == ARB) || ((state == WAIT) && (wait_cnt == 2'd0)));

  always_comb begin
    win = 1'b0;
    if (lock_hold && (last_grant ? m1_req : m0_req))
      win = last_grant;
    else if (m0_req && !m1_req)
      win = 1'b0;
    else if (m1_req && !m0_req)
      win = 1'b1;
    else if (FIXED_PRIO)
      win = 1'b0;
    else
      win = ~last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      wait_cnt   <= 2'd0;
      last_grant <= 1'b1;
      lock_hold  <= 1'b0;
      cur_we     <= 1'b0;
      grant_id   <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= 16'h0000;
      m1_rdata   <= 16'h0000;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_out    <= 16'h0000;
    end else begin
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        ARB: state <= ARB;
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (!cur_we) begin
              if (grant_id) begin
                m1_rdata  <= mem_in;
                m1_rvalid <= 1'b1;
              end else begin
                m0_rdata  <= mem_in;
                m0_rvalid <= 1'b1;
              end
            end
            state <= ARB;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: state <= ARB;
      endcase
      // A new issue overrides the ARB/WAIT fall-through above.
      if (decide) begin
        state      <= ISSUE;
        mem_en     <= 1'b1;
        mem_we     <= win ? m1_we : m0_we;
        cur_we     <= win ? m1_we : m0_we;
        mem_addr   <= win ? m1_addr : m0_addr;
        mem_out    <= win ? m1_wdata : m0_wdata;
        lock_hold  <= win ? m1_lock : m0_lock;
        grant_id   <= win;
        last_grant <= win;
        if (win)
          m1_ack <= 1'b1;
        else
          m0_ack <= 1'b1;
      end
    end
  end

endmodule
